// File: rtl/frame_reader_if.sv
// frame_reader bus bundle: SRAM read port plus the outgoing byte stream.
// master = reader side (drives RE/Addr/tx), slave = SRAM model + byte sink.
interface frame_reader_if #(
  parameter int ADDR_W = 18
);
  logic              s1_RE;
  logic [ADDR_W-1:0] s1_Addr;
  logic [31:0]       s1_RD;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output s1_RE, s1_Addr, tx_data, tx_valid,
    input  s1_RD, tx_ready
  );

  modport slave (
    input  s1_RE, s1_Addr, tx_data, tx_valid,
    output s1_RD, tx_ready
  );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: drains a captured frame from SRAM as a valid/ready byte stream.
// Ports: clk, reset_n (async low), read_kick (edge start), read_abort,
//   last_addr (end word), bus (frame_reader_if.master: s1_RE/s1_Addr/s1_RD,
//   tx_data/tx_valid/tx_ready), read_busy, read_done (1-cycle pulse).
// Optional: define FRAME_READER_HEADER_EN to prepend A5 + 19-bit word count.
module frame_reader #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_kick,
  input  logic              read_abort,
  input  logic [ADDR_W-1:0] last_addr,
  frame_reader_if.master    bus,
  output logic              read_busy,
  output logic              read_done
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              kick_q, kick_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] r_end_q, r_end_d;
  logic [2:0]        lat_q, lat_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;

  logic              kick_edge;
  logic              xfer;
  logic              re;
  logic [ADDR_W-1:0] addr_o;
  logic              valid;
  logic [7:0]        data;
  logic              busy;
  logic              done;

`ifdef FRAME_READER_HEADER_EN
  logic [23:0] cnt24;
  logic [31:0] hdr_word;
  // Header rides in the word buffer so HDR reuses the SEND byte mux.
  always_comb begin
    cnt24    = 24'(last_addr) + 24'd1;
    hdr_word = {cnt24, 8'hA5};
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kick_q  <= 1'b0;
      addr_q  <= '0;
      r_end_q <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      kick_q  <= kick_d;
      addr_q  <= addr_d;
      r_end_q <= r_end_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kick_d    = read_kick;
    addr_d    = addr_q;
    r_end_d   = r_end_q;
    lat_d     = lat_q;
    idx_d     = idx_q;
    word_d    = word_q;
    kick_edge = read_kick & ~kick_q;
    xfer      = valid & bus.tx_ready;
    if (read_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (kick_edge) begin
            r_end_d = last_addr;
            addr_d  = '0;
            idx_d   = '0;
`ifdef FRAME_READER_HEADER_EN
            word_d  = hdr_word;
            state_d = S_HDR;
`else
            state_d = S_REQ;
`endif
          end
        end
`ifdef FRAME_READER_HEADER_EN
        S_HDR: begin
          if (xfer) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = S_REQ;
          end
        end
`endif
        S_REQ: begin
          lat_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            word_d  = bus.s1_RD;
            idx_d   = '0;
            state_d = S_SEND;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            idx_d = idx_q + 2'd1;
            // Compare before increment: the address never wraps.
            if (idx_q == 2'd3) begin
              if (addr_q == r_end_q) begin
                state_d = S_DONE;
              end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_REQ;
              end
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    re     = 1'b1;
    addr_o = '1;
    valid  = 1'b0;
    data   = '0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_HDR: begin
        valid = 1'b1;
        data  = word_q[{idx_q, 3'b000} +: 8];
        busy  = 1'b1;
      end
      S_REQ: begin
        re     = 1'b0;
        addr_o = addr_q;
        busy   = 1'b1;
      end
      S_WAIT: begin
        addr_o = addr_q;
        busy   = 1'b1;
      end
      S_SEND: begin
        addr_o = addr_q;
        valid  = 1'b1;
        data   = word_q[{idx_q, 3'b000} +: 8];
        busy   = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.s1_RE    = re;
  assign bus.s1_Addr  = addr_o;
  assign bus.tx_valid = valid;
  assign bus.tx_data  = data;
  assign read_busy    = busy;
  assign read_done    = done;

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: two readers (RD_LAT 1 and 3) share control and tx_ready;
// each has its own SRAM model and is checked against a byte-stream model.
module tb_frame_reader;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
`ifdef FRAME_READER_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_kick;
  logic        read_abort;
  logic [17:0] last_addr;
  logic        busy0, busy1, done0, done1;
  logic        tx_ready;

  frame_reader_if #(.ADDR_W(18)) bus0 ();
  frame_reader_if #(.ADDR_W(18)) bus1 ();

  frame_reader #(.RD_LAT(LAT0), .ADDR_W(18)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .read_kick(read_kick),
    .read_abort(read_abort), .last_addr(last_addr), .bus(bus0),
    .read_busy(busy0), .read_done(done0)
  );

  frame_reader #(.RD_LAT(LAT1), .ADDR_W(18)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .read_kick(read_kick),
    .read_abort(read_abort), .last_addr(last_addr), .bus(bus1),
    .read_busy(busy1), .read_done(done1)
  );

  always #5 clk = ~clk;

  assign bus0.tx_ready = tx_ready;
  assign bus1.tx_ready = tx_ready;

  // SRAM models: data for an address cycle appears RD_LAT cycles later.
  logic [31:0] mem [64];
  logic [31:0] pipe0 [8];
  logic [31:0] pipe1 [8];
  always @(posedge clk) begin
    pipe0[0] <= !bus0.s1_RE ? mem[bus0.s1_Addr[5:0]] : 32'hdeadbeef;
    pipe1[0] <= !bus1.s1_RE ? mem[bus1.s1_Addr[5:0]] : 32'hdeadbeef;
    for (int i = 1; i < 8; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign bus0.s1_RD = pipe0[LAT0-1];
  assign bus1.s1_RD = pipe1[LAT1-1];

  logic        m_valid [2];
  logic        m_re    [2];
  logic [7:0]  m_data  [2];
  logic [17:0] m_addr  [2];
  logic        m_busy  [2];
  logic        m_done  [2];
  assign m_valid[0] = bus0.tx_valid;
  assign m_valid[1] = bus1.tx_valid;
  assign m_re[0]    = bus0.s1_RE;
  assign m_re[1]    = bus1.s1_RE;
  assign m_data[0]  = bus0.tx_data;
  assign m_data[1]  = bus1.tx_data;
  assign m_addr[0]  = bus0.s1_Addr;
  assign m_addr[1]  = bus1.s1_Addr;
  assign m_busy[0]  = busy0;
  assign m_busy[1]  = busy1;
  assign m_done[0]  = done0;
  assign m_done[1]  = done1;

  // Monitor logs: accepted bytes, read addresses, done pulses, idle gaps.
  logic [7:0]  got [2][4096];
  logic [17:0] req [2][1024];
  int          gap [2][1024];
  int          gcnt [2];
  int          rcnt [2];
  int          dcnt [2];
  int          gpcnt [2];
  int          run [2];
  bit          st_pend [2];
  logic [7:0]  st_data [2];
  int          stall_err;
  int          stall_chk;

  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        if (st_pend[k]) begin
          stall_chk++;
          if (!m_valid[k] || m_data[k] !== st_data[k]) stall_err++;
        end
        st_pend[k] = m_valid[k] && !tx_ready;
        st_data[k] = m_data[k];
        if (m_valid[k] && tx_ready) begin
          got[k][gcnt[k] & 4095] = m_data[k];
          gcnt[k]++;
        end
        if (!m_re[k]) begin
          req[k][rcnt[k] & 1023] = m_addr[k];
          rcnt[k]++;
        end
        if (m_done[k]) dcnt[k]++;
        if (m_busy[k] && !m_valid[k]) begin
          run[k]++;
        end else begin
          if (m_valid[k] && run[k] > 0) begin
            gap[k][gpcnt[k] & 1023] = run[k];
            gpcnt[k]++;
          end
          run[k] = 0;
        end
      end
    end
  end

  // tx_ready driver: held high, or random per cycle in mode 1.
  int ready_mode = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int passed = 0;
  int total  = 0;
  int cur_L;
  int base_g [2];
  int base_r [2];
  int base_d [2];
  int base_p [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Reference stream: optional header, then words 0..L LSB-first.
  function automatic logic [7:0] exp_byte(input int L, input int i);
    int          j;
    logic [31:0] w;
    logic [23:0] c;
    c = 24'(L) + 24'd1;
    if (i < HDR) begin
      w = {c, 8'hA5};
      return w[8*i +: 8];
    end
    j = i - HDR;
    w = mem[(j / 4) % 64];
    return w[8*(j % 4) +: 8];
  endfunction

  function automatic logic [7:0] got_at(input int k, input int i);
    return got[k][(base_g[k] + i) & 4095];
  endfunction

  task automatic snap();
    for (int k = 0; k < 2; k++) begin
      base_g[k] = gcnt[k];
      base_r[k] = rcnt[k];
      base_d[k] = dcnt[k];
      base_p[k] = gpcnt[k];
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  task automatic kick(input int L);
    snap();
    cur_L = L;
    last_addr = 18'(L);
    @(posedge clk); #2 read_kick = 1'b1;
    @(posedge clk); #2 read_kick = 1'b0;
    last_addr = 18'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (dcnt[0] > base_d[0] && dcnt[1] > base_d[1]) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    read_kick = 1'b0;
    read_abort = 1'b0;
    last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (m_re[k] !== 1'b1) $display("FAIL rst_re k%0d: got %b want 1", k, m_re[k]); else passed++;
      total++; if (m_addr[k] !== 18'h3ffff) $display("FAIL rst_addr k%0d: got %h want 3ffff", k, m_addr[k]); else passed++;
      total++; if (m_valid[k] !== 1'b0) $display("FAIL rst_valid k%0d: got %b want 0", k, m_valid[k]); else passed++;
      total++; if (m_data[k] !== 8'h00) $display("FAIL rst_data k%0d: got %h want 00", k, m_data[k]); else passed++;
      total++; if (m_busy[k] !== 1'b0) $display("FAIL rst_busy k%0d: got %b want 0", k, m_busy[k]); else passed++;
      total++; if (m_done[k] !== 1'b0) $display("FAIL rst_done k%0d: got %b want 0", k, m_done[k]); else passed++;
    end
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (m_busy[k] !== 1'b0) $display("FAIL post_rst_busy k%0d: got %b want 0", k, m_busy[k]); else passed++;
    end
  endtask

  task automatic test_single_word();
    bit ok;
    fill_mem();
    mem[0] = 32'h44332211;
    kick(0);
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL single_timeout: got no done want done"); else passed++;
    for (int k = 0; k < 2; k++) begin
      total++; if (gcnt[k] - base_g[k] !== HDR + 4) $display("FAIL single_count k%0d: got %0d want %0d", k, gcnt[k] - base_g[k], HDR + 4); else passed++;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] lit;
        lit = 8'(8'h11 * (i + 1));
        total++; if (got_at(k, HDR + i) !== lit) $display("FAIL single_byte%0d k%0d: got %h want %h", i, k, got_at(k, HDR + i), lit); else passed++;
      end
      total++; if (rcnt[k] - base_r[k] !== 1) $display("FAIL single_reads k%0d: got %0d want 1", k, rcnt[k] - base_r[k]); else passed++;
      total++; if (req[k][base_r[k] & 1023] !== 18'h0) $display("FAIL single_addr k%0d: got %h want 0", k, req[k][base_r[k] & 1023]); else passed++;
      total++; if (dcnt[k] - base_d[k] !== 1) $display("FAIL single_done k%0d: got %0d want 1", k, dcnt[k] - base_d[k]); else passed++;
    end
  endtask

  task automatic test_latency();
    bit ok;
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 4; b++)
        mem[w][8*b +: 8] = 8'(16 * w + b + 1);
    kick(2);
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL lat_timeout: got no done want done"); else passed++;
    for (int k = 0; k < 2; k++) begin
      total++; if (gcnt[k] - base_g[k] !== HDR + 12) $display("FAIL lat_count k%0d: got %0d want %0d", k, gcnt[k] - base_g[k], HDR + 12); else passed++;
      for (int i = 0; i < HDR + 12; i++) begin
        total++; if (got_at(k, i) !== exp_byte(2, i)) $display("FAIL lat_byte%0d k%0d: got %h want %h", i, k, got_at(k, i), exp_byte(2, i)); else passed++;
      end
      total++; if (rcnt[k] - base_r[k] !== 3) $display("FAIL lat_reads k%0d: got %0d want 3", k, rcnt[k] - base_r[k]); else passed++;
      for (int i = 0; i < 3; i++) begin
        total++; if (req[k][(base_r[k] + i) & 1023] !== 18'(i)) $display("FAIL lat_addr%0d k%0d: got %h want %h", i, k, req[k][(base_r[k] + i) & 1023], i); else passed++;
      end
      total++; if (gpcnt[k] - base_p[k] !== 3) $display("FAIL lat_gaps k%0d: got %0d want 3", k, gpcnt[k] - base_p[k]); else passed++;
      for (int i = 0; i < 3; i++) begin
        total++; if (gap[k][(base_p[k] + i) & 1023] !== lat_of(k) + 1) $display("FAIL lat_gap%0d k%0d: got %0d want %0d", i, k, gap[k][(base_p[k] + i) & 1023], lat_of(k) + 1); else passed++;
      end
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    int L;
    int bad;
    ready_mode = 1;
    for (int r = 0; r < 5; r++) begin
      fill_mem();
      L = $urandom_range(0, 15);
      kick(L);
      wait_done(3000, ok);
      total++; if (!ok) $display("FAIL rnd_timeout run%0d: got no done want done", r); else passed++;
      for (int k = 0; k < 2; k++) begin
        total++; if (gcnt[k] - base_g[k] !== HDR + 4 * (L + 1)) $display("FAIL rnd_count run%0d k%0d: got %0d want %0d", r, k, gcnt[k] - base_g[k], HDR + 4 * (L + 1)); else passed++;
        bad = 0;
        for (int i = 0; i < HDR + 4 * (L + 1); i++)
          if (got_at(k, i) !== exp_byte(L, i)) bad++;
        total++; if (bad != 0) $display("FAIL rnd_bytes run%0d k%0d: got %0d wrong bytes want 0", r, k, bad); else passed++;
        bad = 0;
        for (int i = 0; i <= L; i++)
          if (req[k][(base_r[k] + i) & 1023] !== 18'(i)) bad++;
        total++; if (bad != 0 || rcnt[k] - base_r[k] != L + 1) $display("FAIL rnd_addrs run%0d k%0d: got %0d reads %0d wrong want %0d reads", r, k, rcnt[k] - base_r[k], bad, L + 1); else passed++;
      end
    end
    ready_mode = 0;
    repeat (2) @(posedge clk);
    total++; if (stall_err != 0 || stall_chk == 0) $display("FAIL stall_stable: got %0d errors in %0d stalls want 0 errors", stall_err, stall_chk); else passed++;
  endtask

  task automatic test_abort();
    bit ok;
    int n1;
    fill_mem();
    kick(10);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (gcnt[0] - base_g[0] >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL abort_wait: got %0d bytes want 5", gcnt[0] - base_g[0]); else passed++;
    read_abort = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (m_valid[k] !== 1'b0) $display("FAIL abort_valid k%0d: got %b want 0", k, m_valid[k]); else passed++;
      total++; if (m_busy[k] !== 1'b0) $display("FAIL abort_busy k%0d: got %b want 0", k, m_busy[k]); else passed++;
      total++; if (m_addr[k] !== 18'h3ffff) $display("FAIL abort_addr k%0d: got %h want 3ffff", k, m_addr[k]); else passed++;
    end
    #1 read_abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (dcnt[k] !== base_d[k]) $display("FAIL abort_nodone k%0d: got %0d pulses want 0", k, dcnt[k] - base_d[k]); else passed++;
    end
    total++; if (gcnt[0] - base_g[0] !== 5) $display("FAIL abort_count: got %0d want 5", gcnt[0] - base_g[0]); else passed++;
    n1 = gcnt[1] - base_g[1];
    for (int i = 0; i < n1 && i < 5; i++) begin
      total++; if (got_at(1, i) !== exp_byte(10, i)) $display("FAIL abort_prefix%0d: got %h want %h", i, got_at(1, i), exp_byte(10, i)); else passed++;
    end
    kick(1);
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL restart_timeout: got no done want done"); else passed++;
    for (int k = 0; k < 2; k++) begin
      total++; if (req[k][base_r[k] & 1023] !== 18'h0) $display("FAIL restart_addr k%0d: got %h want 0", k, req[k][base_r[k] & 1023]); else passed++;
      total++; if (got_at(k, HDR + 4) !== exp_byte(1, HDR + 4)) $display("FAIL restart_byte k%0d: got %h want %h", k, got_at(k, HDR + 4), exp_byte(1, HDR + 4)); else passed++;
    end
  endtask

  task automatic test_kick_busy();
    bit ok;
    fill_mem();
    kick(8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2 read_kick = 1'b1;
      @(posedge clk); #2 read_kick = 1'b0;
    end
    wait_done(800, ok);
    total++; if (!ok) $display("FAIL busykick_timeout: got no done want done"); else passed++;
    for (int k = 0; k < 2; k++) begin
      total++; if (dcnt[k] - base_d[k] !== 1) $display("FAIL busykick_done k%0d: got %0d want 1", k, dcnt[k] - base_d[k]); else passed++;
      total++; if (rcnt[k] - base_r[k] !== 9) $display("FAIL busykick_reads k%0d: got %0d want 9", k, rcnt[k] - base_r[k]); else passed++;
      total++; if (gcnt[k] - base_g[k] !== HDR + 36) $display("FAIL busykick_count k%0d: got %0d want %0d", k, gcnt[k] - base_g[k], HDR + 36); else passed++;
    end
    snap();
    cur_L = 0;
    last_addr = '0;
    @(posedge clk); #2 read_kick = 1'b1;
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL held_timeout: got no done want done"); else passed++;
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (dcnt[k] - base_d[k] !== 1) $display("FAIL held_norestart k%0d: got %0d runs want 1", k, dcnt[k] - base_d[k]); else passed++;
      total++; if (m_busy[k] !== 1'b0) $display("FAIL held_busy k%0d: got %b want 0", k, m_busy[k]); else passed++;
    end
    snap();
    #1 read_kick = 1'b0;
    @(posedge clk); #2 read_kick = 1'b1;
    @(posedge clk); #2 read_kick = 1'b0;
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL rekick_timeout: got no done want done"); else passed++;
  endtask

`ifdef FRAME_READER_HEADER_EN
  task automatic test_header();
    bit ok;
    logic [7:0] lit [4];
    lit[0] = 8'hA5; lit[1] = 8'h46; lit[2] = 8'h23; lit[3] = 8'h01;
    fill_mem();
    kick(18'h12345);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (gcnt[0] - base_g[0] >= 8 && gcnt[1] - base_g[1] >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL hdr_wait: got %0d bytes want 8", gcnt[0] - base_g[0]); else passed++;
    read_abort = 1'b1;
    @(posedge clk); #2 read_abort = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        total++; if (got_at(k, i) !== lit[i]) $display("FAIL hdr_byte%0d k%0d: got %h want %h", i, k, got_at(k, i), lit[i]); else passed++;
      end
    for (int i = 4; i < 8; i++) begin
      total++; if (got_at(0, i) !== exp_byte(18'h12345, i)) $display("FAIL hdr_data%0d: got %h want %h", i, got_at(0, i), exp_byte(18'h12345, i)); else passed++;
    end
    repeat (4) @(posedge clk);
  endtask
`endif

  task automatic test_async_reset();
    bit ok;
    fill_mem();
    kick(5);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (gcnt[0] - base_g[0] >= 2 && busy1) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) $display("FAIL arst_wait: got %0d bytes want 2", gcnt[0] - base_g[0]); else passed++;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (m_valid[k] !== 1'b0) $display("FAIL arst_valid k%0d: got %b want 0", k, m_valid[k]); else passed++;
      total++; if (m_re[k] !== 1'b1) $display("FAIL arst_re k%0d: got %b want 1", k, m_re[k]); else passed++;
      total++; if (m_addr[k] !== 18'h3ffff) $display("FAIL arst_addr k%0d: got %h want 3ffff", k, m_addr[k]); else passed++;
      total++; if (m_busy[k] !== 1'b0) $display("FAIL arst_busy k%0d: got %b want 0", k, m_busy[k]); else passed++;
      total++; if (m_data[k] !== 8'h00) $display("FAIL arst_data k%0d: got %h want 00", k, m_data[k]); else passed++;
    end
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy0 !== 1'b0) $display("FAIL arst_idle: got busy %b want 0", busy0); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_latency();
    test_random_ready();
    test_abort();
    test_kick_busy();
`ifdef FRAME_READER_HEADER_EN
    test_header();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
